// File: rtl/encryption_process_if.sv
// Bus bundle between the ACORN-128 plaintext stage and its neighbours:
// start/capture inputs, ciphertext and final-state outputs, status flags.
interface encryption_process_if #(
  parameter int PT_BITS = 128
) ();
  logic               start_enc;
  logic [292:0]       state_in;
  logic [PT_BITS-1:0] pt_in;
  logic [PT_BITS-1:0] ct_out;
  logic [292:0]       state_out;
  logic               busy;
  logic               done;

  modport master (
    output start_enc, state_in, pt_in,
    input  ct_out, state_out, busy, done
  );

  modport slave (
    input  start_enc, state_in, pt_in,
    output ct_out, state_out, busy, done
  );
endinterface

// File: rtl/encryption_process.sv
// ACORN-128 plaintext stage: one state update per plaintext bit (emitting
// ciphertext), then 256 padding updates, then a one-cycle done pulse.

// One ACORN-128 StateUpdate128 step, purely combinational; clk/rst only
// qualify the input sanity check.
module state_update128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         ca_in,
  input  logic         cb_in,
  input  logic         mbit_in,
  input  logic [292:0] state_io,
  output logic [292:0] sup128_out,
  output logic         ks_out
);
  logic [292:0] u;
  logic         f;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // All linear feedback taps use the pre-update state values.
  always_comb begin
    u      = state_io;
    u[289] = state_io[289] ^ state_io[235] ^ state_io[230];
    u[230] = state_io[230] ^ state_io[196] ^ state_io[193];
    u[193] = state_io[193] ^ state_io[160] ^ state_io[154];
    u[154] = state_io[154] ^ state_io[111] ^ state_io[107];
    u[107] = state_io[107] ^ state_io[66]  ^ state_io[61];
    u[61]  = state_io[61]  ^ state_io[23]  ^ state_io[0];
    ks_out = u[12] ^ u[154] ^ maj(u[235], u[61], u[193]) ^ ch(u[230], u[111], u[66]);
    f      = state_io[0] ^ ~u[107] ^ maj(state_io[244], state_io[23], state_io[160])
           ^ (ca_in & state_io[196]) ^ (cb_in & ks_out) ^ mbit_in;
    sup128_out = {f, u[292:1]};
  end

  assert property (@(posedge clk) disable iff (rst) !$isunknown({ca_in, cb_in, mbit_in}));
endmodule

// state | meaning
// IDLE  | waiting for start_enc, registers hold
// ENC   | one plaintext bit per cycle, ciphertext bit written
// PAD   | 256 padding updates (m=1 on first, ca=1 for first 128)
// DONE  | one-cycle done pulse, back to IDLE
module encryption_process #(
  parameter int PT_BITS = 128
) (
  input logic clk,
  input logic rst,
  encryption_process_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENC, PAD, DONE} state_t;

  localparam logic [8:0] LAST_ENC = 9'(PT_BITS - 1);

  state_t             state, state_next;
  logic [292:0]       state_reg, sup128_out;
  logic [PT_BITS-1:0] pt_reg, ct_reg, one_hot;
  logic [8:0]         cnt;
  logic               ks, m, ca, cb, load, step, ct_we, cnt_clr;

  assign one_hot = PT_BITS'(1) << cnt;

  state_update128 u_sup (
    .clk        (clk),
    .rst        (rst),
    .ca_in      (ca),
    .cb_in      (cb),
    .mbit_in    (m),
    .state_io   (state_reg),
    .sup128_out (sup128_out),
    .ks_out     (ks)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    m          = 1'b0;
    ca         = 1'b0;
    cb         = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    ct_we      = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_enc) begin
          load       = 1'b1;
          state_next = ENC;
        end
      end
      ENC: begin
        m     = |(pt_reg & one_hot);
        ca    = 1'b1;
        step  = 1'b1;
        ct_we = 1'b1;
        if (cnt == LAST_ENC) begin
          cnt_clr    = 1'b1;
          state_next = PAD;
        end
      end
      PAD: begin
        m    = (cnt == 9'd0);
        ca   = (cnt < 9'd128);
        step = 1'b1;
        if (cnt == 9'd255) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      pt_reg    <= '0;
      ct_reg    <= '0;
      cnt       <= '0;
    end else if (load) begin
      state_reg <= bus.state_in;
      pt_reg    <= bus.pt_in;
      ct_reg    <= '0;
      cnt       <= '0;
    end else if (step) begin
      state_reg <= sup128_out;
      if (ct_we) ct_reg <= (ct_reg & ~one_hot) | (one_hot & {PT_BITS{m ^ ks}});
      cnt <= cnt_clr ? 9'd0 : cnt + 9'd1;
    end
  end

  assign bus.ct_out    = ct_reg;
  assign bus.state_out = state_reg;
  assign bus.busy      = (state == ENC) || (state == PAD);
  assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_encryption_process.sv
// Bench for encryption_process: a 128-bit and a 1-bit build checked against
// a bit-serial ACORN-128 encrypt + padding reference model.
module tb_encryption_process;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  encryption_process_if #(.PT_BITS(128)) a ();
  encryption_process_if #(.PT_BITS(1))   b ();

  encryption_process #(.PT_BITS(128)) dut  (.clk(clk), .rst(rst), .bus(a.slave));
  encryption_process #(.PT_BITS(1))   dut1 (.clk(clk), .rst(rst), .bus(b.slave));

  task automatic chk(input string tag, input logic [292:0] obs, input logic [292:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: in-place tap updates then a one-position shift, bit by bit.
  task automatic acorn_step(inout logic [292:0] s, input logic mb, input logic ca,
                            input logic cb, output logic ks);
    logic f;
    s[289] ^= s[235] ^ s[230];
    s[230] ^= s[196] ^ s[193];
    s[193] ^= s[160] ^ s[154];
    s[154] ^= s[111] ^ s[107];
    s[107] ^= s[66]  ^ s[61];
    s[61]  ^= s[23]  ^ s[0];
    ks = s[12] ^ s[154] ^ ((s[235] & s[61]) ^ (s[235] & s[193]) ^ (s[61] & s[193]))
       ^ ((s[230] & s[111]) ^ (~s[230] & s[66]));
    f = s[0] ^ ~s[107] ^ ((s[244] & s[23]) ^ (s[244] & s[160]) ^ (s[23] & s[160]))
      ^ (ca & s[196]) ^ (cb & ks) ^ mb;
    for (int j = 0; j < 292; j++) s[j] = s[j+1];
    s[292] = f;
  endtask

  task automatic model_encrypt(input logic [292:0] st, input logic [255:0] pt, input int nbits,
                               output logic [255:0] ct, output logic [292:0] fs);
    logic ks;
    fs = st;
    ct = '0;
    for (int i = 0; i < nbits; i++) begin
      acorn_step(fs, pt[i], 1'b1, 1'b0, ks);
      ct[i] = pt[i] ^ ks;
    end
    for (int i = 0; i < 256; i++) acorn_step(fs, i == 0, i < 128, 1'b0, ks);
  endtask

  function automatic logic [292:0] rnd293();
    logic [292:0] r = '0;
    for (int i = 0; i < 10; i++) r = {r[260:0], 32'($urandom)};
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  task automatic drive(input bit sel, input logic s, input logic [292:0] st, input logic [255:0] pt);
    if (sel) begin
      b.start_enc = s; b.state_in = st; b.pt_in = pt[0];
    end else begin
      a.start_enc = s; a.state_in = st; a.pt_in = pt[127:0];
    end
  endtask

  function automatic logic [292:0] get_ct(input bit sel);
    return sel ? 293'(b.ct_out) : 293'(a.ct_out);
  endfunction
  function automatic logic [292:0] get_st(input bit sel);
    return sel ? b.state_out : a.state_out;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? b.busy : a.busy;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? b.done : a.done;
  endfunction

  // mode 0: plain run; 1: second start at step 50; 2: reset at step 200
  task automatic run_op(input bit sel, input logic [292:0] st, input logic [255:0] pt,
                        input int mode, input string tag);
    int           lat;
    int           n;
    int           busy_err;
    int           dcount;
    bit           seen;
    logic [255:0] exp_ct;
    logic [292:0] exp_st;
    lat = (sel ? 1 : 128) + 256;
    model_encrypt(st, pt, sel ? 1 : 128, exp_ct, exp_st);
    drive(sel, 1'b1, st, pt);
    @(posedge clk); #1;
    drive(sel, 1'b0, '0, '0);
    n = 0; seen = 0; busy_err = 0;
    while (!seen && n < lat + 20) begin
      @(posedge clk); #1;
      n++;
      if (mode == 1 && n == 50) drive(sel, 1'b1, ~st, ~pt);
      if (mode == 1 && n == 51) drive(sel, 1'b0, '0, '0);
      if (mode == 2 && n == 200) begin
        rst = 1'b1; #1;
        chk({tag, "_rst_ct"}, get_ct(sel), '0);
        chk({tag, "_rst_state"}, get_st(sel), '0);
        chk({tag, "_rst_flags"}, 293'({get_busy(sel), get_done(sel)}), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        dcount = 0;
        repeat (20) begin
          @(posedge clk); #1;
          if (get_done(sel)) dcount++;
        end
        chk({tag, "_no_done"}, 293'(dcount), '0);
        return;
      end
      if (get_done(sel)) seen = 1;
      else if (!get_busy(sel)) busy_err++;
    end
    chk({tag, "_latency"}, 293'(n), 293'(lat));
    chk({tag, "_busy_low_at_done"}, 293'(get_busy(sel)), '0);
    chk({tag, "_busy_while_running"}, 293'(busy_err), '0);
    chk({tag, "_ct"}, get_ct(sel), sel ? 293'(exp_ct[0]) : 293'(exp_ct[127:0]));
    chk({tag, "_state"}, get_st(sel), exp_st);
    dcount = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (get_done(sel)) dcount++;
    end
    chk({tag, "_single_done"}, 293'(dcount), '0);
    chk({tag, "_state_hold"}, get_st(sel), exp_st);
  endtask

  initial begin
    logic [292:0] ctv;
    logic [292:0] s12;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("idle_outputs", {a.ct_out, a.busy, a.done} | a.state_out, '0);
    end

    s12 = '0;
    s12[12] = 1'b1;
    run_op(1'b0, s12, '0, 0, "tap_s12");
    ctv = get_ct(1'b0);
    chk("tap_s12_ct0", 293'(ctv[0]), 293'(1));

    run_op(1'b0, '0, {128'd0, {128{1'b1}}}, 0, "pt_ones");
    ctv = get_ct(1'b0);
    chk("pt_ones_ct0", 293'(ctv[0]), 293'(1));

    for (int i = 0; i < 20; i++) run_op(1'b0, rnd293(), rnd256(), 0, "golden");

    run_op(1'b0, rnd293(), rnd256(), 1, "restart_ignored");

    run_op(1'b0, rnd293(), rnd256(), 2, "mid_reset");
    run_op(1'b0, rnd293(), rnd256(), 0, "after_reset");

    run_op(1'b1, '0, 256'd1, 0, "pt1_one");
    ctv = get_ct(1'b1);
    chk("pt1_one_ct0", 293'(ctv[0]), 293'(1));
    for (int i = 0; i < 4; i++) run_op(1'b1, rnd293(), rnd256(), 0, "pt1_golden");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
